input_memory_fetch: RTL and testbench

Read-side sequencer for the accelerator's input memory: on a start command it issues a burst of sequential reads (base address, word count) to the memory's registered read port and delivers the returned 108-bit pixel windows to the compute core over a valid/ready stream. Sits between the input memory and the convolution datapath. It absorbs the memory's one-cycle read latency and downstream backpressure with a credit-controlled FIFO, so no returned word is ever dropped.

---
 rtl/input_memory_fetch.sv | 149 ++++++++++++++
 tb/tb_input_memory_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_memory_fetch.sv
// Burst read sequencer: streams sequential input-memory words to the core.
// A credit-limited return FIFO absorbs read latency and backpressure.
module input_memory_fetch #(
  parameter int ADD_SIZE   = 12,
  parameter int DATA_SIZE  = 108,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADD_SIZE-1:0]   base_address,
  input  logic [ADD_SIZE:0]     word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_en,
  output logic [ADD_SIZE-1:0]   mem_read_address,
  input  logic [DATA_SIZE-1:0]  mem_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_SIZE-1:0]  out_data,
  output logic                  out_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW+1:0] DEPTH = (PW+2)'(FIFO_DEPTH);
  localparam logic [ADD_SIZE:0] CNT_ONE = (ADD_SIZE+1)'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t state, state_n;
  logic [ADD_SIZE:0]   left, left_n;
  logic [ADD_SIZE-1:0] addr_n;
  logic                en_n, en_last, en_last_n;
  logic                ret, ret_last;
  logic                done_n;

  logic [DATA_SIZE-1:0] fdata [FIFO_DEPTH];
  logic                 flast [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          occ, occ_n;
  logic [PW+1:0]        used;
  logic                 push, pop, last_pop, credit_ok;

  assign push      = ret;
  assign pop       = out_valid & out_ready;
  assign last_pop  = pop & out_last;
  assign out_data  = fdata[rd_ptr];
  assign out_last  = flast[rd_ptr];

  // Entries already held plus reads that will land before a new one would.
  assign used = {1'b0, occ}
              + {{(PW+1){1'b0}}, ret}
              + {{(PW+1){1'b0}}, mem_read_en};
  assign credit_ok = used < DEPTH;

  always_comb begin
    occ_n = occ;
    if (push && !pop)      occ_n = occ + 1'b1;
    else if (!push && pop) occ_n = occ - 1'b1;
  end

  always_comb begin
    state_n   = state;
    left_n    = left;
    addr_n    = mem_read_address;
    en_n      = 1'b0;
    en_last_n = 1'b0;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            done_n = 1'b1;
          end else begin
            state_n   = FETCH;
            en_n      = 1'b1;
            addr_n    = base_address;
            left_n    = word_count - CNT_ONE;
            en_last_n = (word_count == CNT_ONE);
          end
        end
      end
      FETCH: begin
        if (left == '0) begin
          state_n = DRAIN;
        end else if (credit_ok) begin
          en_n      = 1'b1;
          addr_n    = mem_read_address + 1'b1;
          left_n    = left - CNT_ONE;
          en_last_n = (left == CNT_ONE);
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      left             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_read_en      <= 1'b0;
      mem_read_address <= '0;
      en_last          <= 1'b0;
      ret              <= 1'b0;
      ret_last         <= 1'b0;
    end else begin
      state            <= state_n;
      left             <= left_n;
      busy             <= (state_n != IDLE);
      done             <= done_n;
      mem_read_en      <= en_n;
      mem_read_address <= addr_n;
      en_last          <= en_last_n;
      ret              <= mem_read_en;
      ret_last         <= en_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fdata[i] <= '0;
        flast[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fdata[wr_ptr] <= mem_read_data;
        flast[wr_ptr] <= ret_last;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ       <= occ_n;
      out_valid <= (occ_n != '0);
    end
  end

endmodule

// File: tb/tb_input_memory_fetch.sv
// Randomized scoreboard bench for input_memory_fetch.
// Expected reads/words come from base+i over a RAM model.
module tb_input_memory_fetch;

  logic         clk = 0;
  logic         rst = 0;
  logic         start = 0;
  logic [11:0]  base_address = 0;
  logic [12:0]  word_count = 0;
  logic         busy, done, mem_read_en;
  logic [11:0]  mem_read_address;
  logic [107:0] mem_read_data = 0;
  logic         out_valid, out_ready;
  logic [107:0] out_data;
  logic         out_last;

  input_memory_fetch dut (
    .clk(clk), .rst(rst), .start(start),
    .base_address(base_address), .word_count(word_count),
    .busy(busy), .done(done),
    .mem_read_en(mem_read_en), .mem_read_address(mem_read_address),
    .mem_read_data(mem_read_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  logic [107:0] ram [4096];
  always @(posedge clk) if (mem_read_en) mem_read_data <= ram[mem_read_address];

  int cmp = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int rdy_mode = 0;
  logic [108:0] exp_q[$];
  logic [11:0]  addr_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    cmp++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h t=%0t", nm, act, req, $time);
    end
  endtask

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 0;
      endcase
    end
  end

  // Read address monitor
  always @(negedge clk) if (rst && mem_read_en) begin
    if (addr_q.size() == 0) chk("extra_read", 1, 0);
    else chk("read_addr", mem_read_address, addr_q.pop_front());
  end

  // Output word monitor
  always @(negedge clk) if (rst && out_valid && out_ready) begin
    if (exp_q.size() == 0) chk("extra_word", 1, 0);
    else chk("out_word", {out_last, out_data}, exp_q.pop_front());
  end

  // Stall stability monitor
  logic         hold = 0;
  logic [108:0] held = 0;
  always @(negedge clk) begin
    if (!rst) hold = 0;
    else begin
      if (hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", {out_last, out_data}, held);
      end
      hold = out_valid && !out_ready;
      held = {out_last, out_data};
    end
  end

  always @(negedge clk) if (rst && done) begin
    chk("done_expected", done_cnt < exp_done, 1);
    done_cnt++;
  end

  task automatic do_start(input logic [11:0] b, input logic [12:0] n, input bit accept);
    @(posedge clk); #1;
    start = 1; base_address = b; word_count = n;
    if (accept) begin
      exp_done++;
      for (int i = 0; i < int'(n); i++) begin
        logic [11:0] a;
        a = 12'((int'(b) + i) % 4096);
        addr_q.push_back(a);
        exp_q.push_back({(i == int'(n) - 1), ram[a]});
      end
    end
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt < exp_done && k < budget) begin
      @(negedge clk); k++;
    end
    chk("done_timeout", done_cnt >= exp_done, 1);
    @(negedge clk);
    chk("words_left", exp_q.size(), 0);
    chk("reads_left", addr_q.size(), 0);
  endtask

  task automatic basic_burst(input logic [11:0] b);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    do_start(b, 13'd5, 1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("bb_en_c%0d", k), mem_read_en, (k >= 1 && k <= 5));
      chk($sformatf("bb_valid_c%0d", k), out_valid, (k >= 3 && k <= 7));
      chk($sformatf("bb_last_c%0d", k), out_valid & out_last, (k == 7));
      chk($sformatf("bb_done_c%0d", k), done, (k == 8));
      chk($sformatf("bb_busy_c%0d", k), busy, (k >= 1 && k <= 7));
    end
    chk("bb_words_left", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      ram[i] = r[107:0];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", mem_read_en, 0);
    chk("rst_addr", mem_read_address, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    rst = 1;

    basic_burst(12'h010);

    rdy_mode = 1;
    do_start(12'hFFE, 13'd4, 1);
    wait_done(200);

    // Backpressure: exactly FIFO_DEPTH reads while stalled
    begin
      int reads = 0;
      rdy_mode = 2;
      repeat (3) @(posedge clk);
      do_start(12'h123, 13'd10, 1);
      for (int k = 1; k <= 19; k++) begin
        @(negedge clk);
        if (mem_read_en) reads++;
      end
      chk("bp_reads", reads, 4);
      rdy_mode = 0;
      wait_done(200);
    end

    rdy_mode = 1;
    do_start(12'h200, 13'd10, 1);
    wait_done(300);

    // Zero count
    rdy_mode = 0;
    do_start(12'h055, 13'd0, 1);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_en", mem_read_en, 0);
    chk("zero_busy", busy, 0);
    repeat (3) @(negedge clk);

    // Start while busy is ignored
    rdy_mode = 1;
    do_start(12'h300, 13'd8, 1);
    do_start(12'h700, 13'd5, 0);
    wait_done(300);
    repeat (10) @(negedge clk);
    chk("busy_start_dones", done_cnt, exp_done);

    for (int t = 0; t < 6; t++) begin
      rdy_mode = 1;
      do_start(12'($urandom), 13'($urandom_range(1, 40)), 1);
      wait_done(1000);
    end

    rdy_mode = 1;
    do_start(12'h9A5, 13'h1000, 1);
    wait_done(20000);

    // Reset in cycle 6 of a 10-word burst
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    do_start(12'h400, 13'd10, 1);
    repeat (5) @(posedge clk);
    #1;
    rst = 0;
    exp_q.delete();
    addr_q.delete();
    exp_done = done_cnt;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", mem_read_en, 0);
    chk("mid_rst_addr", mem_read_address, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1;
    repeat (4) @(negedge clk);
    chk("mid_rst_nodone", done_cnt, exp_done);
    basic_burst(12'h010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
